// File: rtl/shell_pkg.sv
// Shared shell definitions: arbiter state encoding, default requester count
// and the ASCII codes the byte producers emit.
package shell_pkg;

    localparam int DEFAULT_NUM_REQ = 3;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_GT = 8'h3E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/shell_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set request
// searching upward (cyclically) from ptr+1, as a one-hot vector plus valid.
module rr_pick
    import shell_pkg::*;
#(
    parameter int N = DEFAULT_NUM_REQ
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    int idx;

    // The previous winner (ptr) is visited last, which makes it lowest priority.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx[IW-1:0]]) begin
                grant[idx[IW-1:0]] = 1'b1;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shell_tx_arbiter.sv
// shell_tx_arbiter: round-robin, message-locked arbiter in front of UART_TX.
// Optional stall watchdog enabled by defining SHELL_TX_ARB_TIMEOUT_EN.
module shell_tx_arbiter
    import shell_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Byte,
    input  logic [NUM_REQ-1:0]   i_Last,
    output logic [NUM_REQ-1:0]   o_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic                 o_Timeout
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CLKS < 1) begin : g_bad_cfg
        $error("shell_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CLKS positive");
    end

    arb_state_t         state;
    arb_state_t         state_n;
    logic [PW-1:0]      r_Ptr;
    logic [PW-1:0]      ptr_n;
    logic               r_Last;
    logic               last_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [NUM_REQ-1:0] ack_n;
    logic               dv_n;
    logic [7:0]         byte_n;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_valid;

    logic [PW-1:0]      owner_idx;
    logic               owner_req;
    logic               owner_last;
    logic [7:0]         owner_byte;

`ifdef SHELL_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   stall_n;
    logic               timeout_n;
`endif

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (i_Req),
        .ptr   (r_Ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // The one-hot grant selects the owner's request, last flag and byte.
    always_comb begin
        owner_idx  = '0;
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_Grant[k]) begin
                owner_idx  = k[PW-1:0];
                owner_req  = i_Req[k];
                owner_last = i_Last[k];
                owner_byte = i_Byte[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = r_Ptr;
        last_n  = r_Last;
        grant_n = o_Grant;
        ack_n   = '0;
        dv_n    = 1'b0;
        byte_n  = o_TX_Byte;
`ifdef SHELL_TX_ARB_TIMEOUT_EN
        stall_n   = '0;
        timeout_n = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_n = pick_grant;
                    state_n = ST_SEND;
                end else begin
                    grant_n = '0;
                end
            end
            ST_SEND: begin
                if (owner_req && !i_TX_Active) begin
                    dv_n    = 1'b1;
                    ack_n   = o_Grant;
                    byte_n  = owner_byte;
                    last_n  = owner_last;
                    state_n = ST_WAIT;
                end
`ifdef SHELL_TX_ARB_TIMEOUT_EN
                else if (!owner_req) begin
                    // A producer that vanished mid-message must not lock the UART forever.
                    if (stall_cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
                        timeout_n = 1'b1;
                        ptr_n     = owner_idx;
                        grant_n   = '0;
                        state_n   = ST_IDLE;
                    end else begin
                        stall_n = stall_cnt + 1'b1;
                    end
                end else begin
                    stall_n = stall_cnt;
                end
`endif
            end
            ST_WAIT: begin
                if (i_TX_Done) begin
                    if (r_Last) begin
                        ptr_n   = owner_idx;
                        grant_n = '0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_SEND;
                    end
                end
            end
            default: begin
                grant_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Reset pointer at the top index so requester 0 wins the first arbitration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            r_Ptr     <= PW'(NUM_REQ - 1);
            r_Last    <= 1'b0;
            o_Grant   <= '0;
            o_Ack     <= '0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
        end else begin
            state     <= state_n;
            r_Ptr     <= ptr_n;
            r_Last    <= last_n;
            o_Grant   <= grant_n;
            o_Ack     <= ack_n;
            o_TX_DV   <= dv_n;
            o_TX_Byte <= byte_n;
        end
    end

`ifdef SHELL_TX_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            o_Timeout <= 1'b0;
        end else begin
            stall_cnt <= stall_n;
            o_Timeout <= timeout_n;
        end
    end
`else
    assign o_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_shell_tx_arbiter.sv
// Directed bench for shell_tx_arbiter: queue-driven producers and a stub
// UART_TX whose done pulse arrives 10 cycles after each load strobe.
module tb_shell_tx_arbiter;
    import shell_pkg::*;

    localparam int NREQ  = 3;
    localparam int TOCLK = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   i_Req;
    logic [8*NREQ-1:0] i_Byte;
    logic [NREQ-1:0]   i_Last;
    logic [NREQ-1:0]   o_Ack;
    logic [NREQ-1:0]   o_Grant;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic              i_TX_Active;
    logic              i_TX_Done;
    logic              o_Timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stub_cnt;
    int proto_err;

    logic [8:0]      prodq [NREQ][$];
    logic [NREQ-1:0] prev_grant;

    int dv_cyc[$];
    int dv_byte[$];
    int dv_own[$];
    int gnt_cyc[$];
    int gnt_val[$];
    int drop_cyc[$];
    int to_cyc[$];
    int ack1_cyc[$];

    shell_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .TIMEOUT_CLKS (TOCLK)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_Req       (i_Req),
        .i_Byte      (i_Byte),
        .i_Last      (i_Last),
        .o_Ack       (o_Ack),
        .o_Grant     (o_Grant),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done),
        .o_Timeout   (o_Timeout)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Stub serializer: busy from the load strobe until a done pulse 10 cycles later.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            i_TX_Active <= 1'b0;
            i_TX_Done   <= 1'b0;
            stub_cnt    <= 0;
        end else begin
            i_TX_Done <= 1'b0;
            if (o_TX_DV) begin
                i_TX_Active <= 1'b1;
                stub_cnt    <= 9;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    i_TX_Done   <= 1'b1;
                    i_TX_Active <= 1'b0;
                end
            end
        end
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic drive();
        logic [8:0] head;
        for (int k = 0; k < NREQ; k++) begin
            head             = (prodq[k].size() != 0) ? prodq[k][0] : 9'h000;
            i_Req[k]         = (prodq[k].size() != 0);
            i_Last[k]        = head[8];
            i_Byte[8*k +: 8] = head[7:0];
        end
    endtask

    task automatic clear_log();
        dv_cyc.delete();
        dv_byte.delete();
        dv_own.delete();
        gnt_cyc.delete();
        gnt_val.delete();
        drop_cyc.delete();
        to_cyc.delete();
        ack1_cyc.delete();
        proto_err = 0;
    endtask

    task automatic step();
        @(negedge CLK);
        if (o_TX_DV) begin
            dv_cyc.push_back(cyc);
            dv_byte.push_back(int'(o_TX_Byte));
            dv_own.push_back(int'(o_Grant));
        end
        if (o_Ack !== (o_TX_DV ? o_Grant : '0) || !$onehot0(o_Grant))
            proto_err++;
        if (o_Ack[1])
            ack1_cyc.push_back(cyc);
        if (o_Grant != prev_grant) begin
            if (o_Grant == '0) begin
                drop_cyc.push_back(cyc);
            end else begin
                gnt_cyc.push_back(cyc);
                gnt_val.push_back(int'(o_Grant));
            end
        end
        prev_grant = o_Grant;
        if (o_Timeout)
            to_cyc.push_back(cyc);
        for (int k = 0; k < NREQ; k++) begin
            if (o_Ack[k] && prodq[k].size() != 0)
                void'(prodq[k].pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        for (int k = 0; k < NREQ; k++)
            prodq[k].delete();
        drive();
        repeat (3) step();
        RST        = 1'b0;
        prev_grant = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive();
        @(negedge CLK);
        @(negedge CLK);
        total++;
        if ({o_Grant, o_Ack, o_TX_DV, o_TX_Byte, o_Timeout} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_values got grant=%b ack=%b dv=%b byte=%h to=%b want all 0",
                     o_Grant, o_Ack, o_TX_DV, o_TX_Byte, o_Timeout);
        end
        RST        = 1'b0;
        prev_grant = '0;
        clear_log();
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (o_Grant !== '0 || o_Ack !== '0 || o_TX_DV !== 1'b0 ||
                o_TX_Byte !== 8'h00 || o_Timeout !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_cycle_%0d got grant=%b ack=%b dv=%b byte=%h to=%b want all 0",
                         i, o_Grant, o_Ack, o_TX_DV, o_TX_Byte, o_Timeout);
            end
        end
    endtask

    task automatic test_single_message();
        int c0;
        clear_log();
        prodq[1].push_back({1'b0, 8'h67});
        prodq[1].push_back({1'b1, ASCII_CR});
        drive();
        c0 = cyc;
        repeat (30) step();
        total++;
        if (qget(gnt_cyc, 0) != c0 + 1 || qget(gnt_val, 0) != 2) begin
            bad++;
            $display("[TB] FAIL single_grant got cyc=%0d val=%0d want cyc=%0d val=2",
                     qget(gnt_cyc, 0), qget(gnt_val, 0), c0 + 1);
        end
        total++;
        if (dv_byte.size() != 2) begin
            bad++;
            $display("[TB] FAIL single_dv_count got=%0d want=2", dv_byte.size());
        end
        total++;
        if (qget(dv_cyc, 0) != c0 + 2 || qget(dv_byte, 0) != 'h67) begin
            bad++;
            $display("[TB] FAIL single_first_byte got cyc=%0d byte=%h want cyc=%0d byte=67",
                     qget(dv_cyc, 0), qget(dv_byte, 0), c0 + 2);
        end
        total++;
        if (qget(dv_cyc, 1) != c0 + 14 || qget(dv_byte, 1) != 'h0D) begin
            bad++;
            $display("[TB] FAIL single_second_byte got cyc=%0d byte=%h want cyc=%0d byte=0d",
                     qget(dv_cyc, 1), qget(dv_byte, 1), c0 + 14);
        end
        total++;
        if (drop_cyc.size() != 1 || qget(drop_cyc, 0) != c0 + 25) begin
            bad++;
            $display("[TB] FAIL single_grant_drop got cyc=%0d n=%0d want cyc=%0d n=1",
                     qget(drop_cyc, 0), drop_cyc.size(), c0 + 25);
        end
        total++;
        if (proto_err != 0) begin
            bad++;
            $display("[TB] FAIL single_ack_protocol got errors=%0d want 0", proto_err);
        end
    endtask

    task automatic test_round_robin();
        int c0;
        do_reset();
        clear_log();
        prodq[0].push_back({1'b1, 8'h41});
        prodq[0].push_back({1'b1, 8'h42});
        prodq[2].push_back({1'b1, 8'h43});
        drive();
        c0 = cyc;
        repeat (45) step();
        total++;
        if (dv_byte.size() != 3) begin
            bad++;
            $display("[TB] FAIL rr_dv_count got=%0d want=3", dv_byte.size());
        end
        total++;
        if (qget(dv_own, 0) != 1 || qget(dv_own, 1) != 4 || qget(dv_own, 2) != 1) begin
            bad++;
            $display("[TB] FAIL rr_order got owners=%0d,%0d,%0d want 1,4,1",
                     qget(dv_own, 0), qget(dv_own, 1), qget(dv_own, 2));
        end
        total++;
        if (qget(dv_byte, 0) != 'h41 || qget(dv_byte, 1) != 'h43 || qget(dv_byte, 2) != 'h42) begin
            bad++;
            $display("[TB] FAIL rr_bytes got %h,%h,%h want 41,43,42",
                     qget(dv_byte, 0), qget(dv_byte, 1), qget(dv_byte, 2));
        end
        total++;
        if (qget(dv_cyc, 0) != c0 + 2 || qget(dv_cyc, 1) != c0 + 15 || qget(dv_cyc, 2) != c0 + 28) begin
            bad++;
            $display("[TB] FAIL rr_dv_timing got %0d,%0d,%0d want %0d,%0d,%0d",
                     qget(dv_cyc, 0), qget(dv_cyc, 1), qget(dv_cyc, 2), c0 + 2, c0 + 15, c0 + 28);
        end
        total++;
        if (qget(drop_cyc, 0) != c0 + 13 || qget(gnt_cyc, 1) != c0 + 14) begin
            bad++;
            $display("[TB] FAIL rr_idle_gap got drop=%0d regrant=%0d want drop=%0d regrant=%0d",
                     qget(drop_cyc, 0), qget(gnt_cyc, 1), c0 + 13, c0 + 14);
        end
        total++;
        if (proto_err != 0) begin
            bad++;
            $display("[TB] FAIL rr_ack_protocol got errors=%0d want 0", proto_err);
        end
    endtask

    task automatic test_no_interleave();
        int c0;
        clear_log();
        prodq[0].push_back({1'b0, 8'h61});
        prodq[0].push_back({1'b0, 8'h62});
        prodq[0].push_back({1'b1, ASCII_LF});
        drive();
        c0 = cyc;
        for (int i = 0; i < 10 && dv_byte.size() == 0; i++)
            step();
        total++;
        if (dv_byte.size() == 0) begin
            bad++;
            $display("[TB] FAIL lock_first_dv got none within 10 cycles want one");
        end
        prodq[1].push_back({1'b1, 8'h78});
        drive();
        repeat (50) step();
        total++;
        if (dv_byte.size() != 4 || qget(dv_byte, 0) != 'h61 || qget(dv_byte, 1) != 'h62 ||
            qget(dv_byte, 2) != 'h0A || qget(dv_byte, 3) != 'h78) begin
            bad++;
            $display("[TB] FAIL lock_stream got n=%0d %h,%h,%h,%h want 61,62,0a,78", dv_byte.size(),
                     qget(dv_byte, 0), qget(dv_byte, 1), qget(dv_byte, 2), qget(dv_byte, 3));
        end
        total++;
        if (qget(dv_own, 0) != 1 || qget(dv_own, 1) != 1 || qget(dv_own, 2) != 1 || qget(dv_own, 3) != 2) begin
            bad++;
            $display("[TB] FAIL lock_owners got %0d,%0d,%0d,%0d want 1,1,1,2",
                     qget(dv_own, 0), qget(dv_own, 1), qget(dv_own, 2), qget(dv_own, 3));
        end
        total++;
        if (ack1_cyc.size() != 1 || qget(ack1_cyc, 0) != c0 + 39 || qget(drop_cyc, 0) != c0 + 37) begin
            bad++;
            $display("[TB] FAIL lock_req1_ack got ack=%0d n=%0d drop=%0d want ack=%0d n=1 drop=%0d",
                     qget(ack1_cyc, 0), ack1_cyc.size(), qget(drop_cyc, 0), c0 + 39, c0 + 37);
        end
        total++;
        if (proto_err != 0) begin
            bad++;
            $display("[TB] FAIL lock_ack_protocol got errors=%0d want 0", proto_err);
        end
    endtask

    task automatic test_reset_in_wait();
        int r;
        clear_log();
        prodq[2].push_back({1'b0, 8'h7A});
        prodq[2].push_back({1'b1, 8'h71});
        drive();
        repeat (5) step();
        total++;
        if (o_Grant !== 3'b100 || dv_byte.size() != 1) begin
            bad++;
            $display("[TB] FAIL rst_pre_state got grant=%b dv_n=%0d want grant=100 dv_n=1",
                     o_Grant, dv_byte.size());
        end
        RST = 1'b1;
        #1;
        total++;
        if ({o_Grant, o_Ack, o_TX_DV, o_TX_Byte, o_Timeout} !== '0) begin
            bad++;
            $display("[TB] FAIL rst_async_clear got grant=%b ack=%b dv=%b byte=%h to=%b want all 0",
                     o_Grant, o_Ack, o_TX_DV, o_TX_Byte, o_Timeout);
        end
        repeat (2) step();
        RST        = 1'b0;
        prev_grant = '0;
        clear_log();
        drive();
        r = cyc;
        repeat (20) step();
        total++;
        if (qget(gnt_cyc, 0) != r + 1 || qget(gnt_val, 0) != 4) begin
            bad++;
            $display("[TB] FAIL rst_regrant got cyc=%0d val=%0d want cyc=%0d val=4",
                     qget(gnt_cyc, 0), qget(gnt_val, 0), r + 1);
        end
        total++;
        if (qget(dv_cyc, 0) != r + 2 || qget(dv_byte, 0) != 'h71 || qget(drop_cyc, 0) != r + 13) begin
            bad++;
            $display("[TB] FAIL rst_resend got dv=%0d byte=%h drop=%0d want dv=%0d byte=71 drop=%0d",
                     qget(dv_cyc, 0), qget(dv_byte, 0), qget(drop_cyc, 0), r + 2, r + 13);
        end
    endtask

    task automatic test_stall();
        int c0;
        do_reset();
        clear_log();
        prodq[0].push_back({1'b0, 8'h73});
        prodq[2].push_back({1'b1, 8'h77});
        drive();
        c0 = cyc;
`ifdef SHELL_TX_ARB_TIMEOUT_EN
        repeat (40) step();
        total++;
        if (to_cyc.size() != 1 || qget(to_cyc, 0) != c0 + 29) begin
            bad++;
            $display("[TB] FAIL stall_timeout got cyc=%0d n=%0d want cyc=%0d n=1",
                     qget(to_cyc, 0), to_cyc.size(), c0 + 29);
        end
        total++;
        if (qget(drop_cyc, 0) != c0 + 29 || qget(gnt_cyc, 1) != c0 + 30 || qget(gnt_val, 1) != 4) begin
            bad++;
            $display("[TB] FAIL stall_regrant got drop=%0d grant=%0d val=%0d want drop=%0d grant=%0d val=4",
                     qget(drop_cyc, 0), qget(gnt_cyc, 1), qget(gnt_val, 1), c0 + 29, c0 + 30);
        end
        total++;
        if (qget(dv_cyc, 1) != c0 + 31 || qget(dv_byte, 1) != 'h77) begin
            bad++;
            $display("[TB] FAIL stall_next_byte got cyc=%0d byte=%h want cyc=%0d byte=77",
                     qget(dv_cyc, 1), qget(dv_byte, 1), c0 + 31);
        end
`else
        begin
            int held;
            held = 0;
            repeat (14) step();
            repeat (1000) begin
                step();
                if (o_Grant == 3'b001)
                    held++;
            end
            total++;
            if (held != 1000) begin
                bad++;
                $display("[TB] FAIL stall_hold got held=%0d want=1000", held);
            end
            total++;
            if (dv_byte.size() != 1 || gnt_cyc.size() != 1 || to_cyc.size() != 0) begin
                bad++;
                $display("[TB] FAIL stall_no_release got dv_n=%0d grants=%0d timeouts=%0d want 1,1,0",
                         dv_byte.size(), gnt_cyc.size(), to_cyc.size());
            end
            do_reset();
        end
`endif
        total++;
        if (proto_err != 0) begin
            bad++;
            $display("[TB] FAIL stall_ack_protocol got errors=%0d want 0", proto_err);
        end
    endtask

    initial begin
        RST    = 1'b1;
        i_Req  = '0;
        i_Byte = '0;
        i_Last = '0;
        prev_grant = '0;
        proto_err  = 0;
        test_reset();
        test_single_message();
        test_round_robin();
        test_no_interleave();
        test_reset_in_wait();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shell_tx_arbiter.md
# shell_tx_arbiter

Round-robin arbiter sharing the shell's single UART transmitter between several byte producers: command echo, response/hex printer and prompt generator. It sits between the producers and the `UART_TX` serializer inside `Shell`. It grants one requester at a time and holds the grant for a whole multi-byte message, so output text from different producers never interleaves. It handshakes every byte against the serializer's active/done signals.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `TIMEOUT_CLKS`, 4096: stall limit for a granted requester; only used with `SHELL_TX_ARB_TIMEOUT_EN`.
- `CLK` in 1: system clock. One clock domain.
- `RST` in 1: reset, asynchronous, active-high.
- `i_Req` in `NUM_REQ`: per requester, a byte is presented.
- `i_Byte` in `8*NUM_REQ`: byte for requester k at `[8k+7:8k]`.
- `i_Last` in `NUM_REQ`: the presented byte ends the message.
- `o_Ack` out `NUM_REQ`: one-cycle pulse, byte of requester k consumed.
- `o_Grant` out `NUM_REQ`: one-hot current owner, or zero.
- `o_TX_DV` out 1: one-cycle load strobe to `UART_TX`.
- `o_TX_Byte` out 8: byte to `UART_TX`, valid with `o_TX_DV`.
- `i_TX_Active` in 1: serializer busy.
- `i_TX_Done` in 1: serializer finished the stop bit (one-cycle pulse).
- `o_Timeout` out 1: one-cycle pulse when a grant is revoked. Present only with the macro; otherwise tied 0.

## Operation
- States are `IDLE`, `SEND`, `WAIT`.
- `IDLE`:
  - If any `i_Req` bit is set, the state goes to `SEND` with `o_Grant` set to the first requesting index, searching upward (cyclically) from `r_Ptr+1`.
  - With no request, the state stays `IDLE` and `o_Grant` is 0.
- `SEND` (owner g):
  - When `i_Req[g]` is high and `i_TX_Active` is low, the block registers `o_TX_DV`=1, `o_TX_Byte`=`i_Byte[g]` and `o_Ack[g]`=1, then goes to `WAIT`.
  - It latches `r_Last`=`i_Last[g]` at the same time.
  - If `i_Req[g]` is low, the block holds the grant and stays in `SEND`. The grant is locked to the message.
- `WAIT`: on `i_TX_Done`:
  - If `r_Last` is set, `r_Ptr` becomes g, `o_Grant` goes to 0 and the state goes to `IDLE`.
  - Otherwise the state goes to `SEND` with the same owner.
- Requests from non-owners are ignored until the owner releases. They are never acked.
- Requesters must keep `i_Byte`/`i_Last` stable while `i_Req` is high and not yet acked. They drop or advance the byte on `o_Ack`.
- `i_TX_Done` seen outside `WAIT` is ignored.
- Reset values (asynchronous):
  - state `IDLE`
  - `r_Ptr` = `NUM_REQ-1`, so requester 0 wins first
  - `o_Grant`, `o_Ack`, `o_TX_DV`, `o_Timeout` = 0
  - `o_TX_Byte` = 8'h00
  - timeout counter = 0
- Reset mid-message abandons the message. The producer's next byte after reset starts a new arbitration.

## Timing
- A request sampled in `IDLE` at edge n gives `o_Grant` at n+1.
- `o_TX_DV`/`o_Ack` are asserted at n+2 when the serializer is idle. First-byte latency is 2 cycles.
- Subsequent bytes: `o_TX_DV` is asserted 2 cycles after the `i_TX_Done` pulse, if `i_Req[g]` is already high.
- `o_Ack` and `o_TX_DV` are always coincident and last exactly 1 cycle.
- A final `i_TX_Done` at edge m clears `o_Grant` at m+1. A new grant appears no earlier than m+2, giving 1 `IDLE` cycle between messages.
- Round-robin order: after owner g releases, priority is g+1, g+2, …, wrapping modulo `NUM_REQ`. g itself is lowest.

## Configuration
- `SHELL_TX_ARB_TIMEOUT_EN` defined:
  - A counter runs in `SEND` while `i_Req[g]` is low.
  - The counter clears on any ack and on leaving `SEND`.
  - When it reaches `TIMEOUT_CLKS`, the block pulses `o_Timeout`, sets `r_Ptr`=g, clears `o_Grant` and goes to `IDLE`.
- Undefined: no counter. A stalled owner holds the grant indefinitely, and `o_Timeout` is constant 0.

## Structure
- `shell_pkg` holds:
  - the state encodings `ST_IDLE`/`ST_SEND`/`ST_WAIT`
  - the default `NUM_REQ`
  - the ASCII constants used by producers (CR 8'h0D, LF 8'h0A, '>' 8'h3E)
- One sub-module, `rr_pick`: combinational, taking `i_Req` and `r_Ptr` and returning a one-hot winner plus a `valid` flag. It is reused by future shell resource arbiters (RAM port).

## Test plan
- Reset, then idle for 20 cycles. Required: all outputs 0, `o_Grant`=0 throughout.
- Requester 1 sends "g" then CR (8'h67, 8'h0D with `i_Last`), using a stub `UART_TX` whose done pulse comes 10 cycles after DV. Required:
  - `o_TX_DV` at +2 cycles carrying 8'h67
  - second DV carrying 8'h0D, 2 cycles after the first done
  - grant drops 1 cycle after the second done
- Requesters 0 and 2 request simultaneously with one-byte messages. Required: 0 is served first, then 2. If 0 re-requests immediately, order is 0, 2, 0.
- While requester 0 is mid-message (first byte sent, not `i_Last`), requester 1 requests. Required: 1 receives no `o_Ack` until 0's last byte completes, and the serial stream shows no interleaving.
- Assert `RST` while in `WAIT`. Required: outputs clear asynchronously before the next edge, and a following request is granted normally.
- With `SHELL_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CLKS`=16, the owner drops `i_Req` mid-message. Required:
  - `o_Timeout` pulses after 16 stalled cycles
  - the grant is cleared and the waiting requester 2 is granted next
  - without the macro, the grant is held for 1000 cycles
